// File: rtl/msg_frm_pkg.sv
// Shared types and helpers for the message framing controller.
// Holds the FSM state encoding, default marker codes and length saturation.
package msg_frm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MSG  = 2'd1,
        BLK  = 2'd2,
        STOP = 2'd3
    } frm_state_e;

    localparam logic [7:0] SOM_CODE_DEF  = 8'h7E;
    localparam logic [7:0] STOP_CODE_DEF = 8'h7F;

    function automatic int unsigned sat_len(
        input int unsigned cnt,
        input int unsigned len_w
    );
        int unsigned max_v;
        max_v = (32'd1 << len_w) - 32'd1;
        return (cnt > max_v) ? max_v : cnt;
    endfunction

endpackage

// File: rtl/msg_frm_tmr.sv
// Loadable down-counter with a zero flag; load wins over decrement.
// Stops at zero so the flag stays asserted until the next load.
module msg_frm_tmr #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/msg_frm_ctrl.sv
// Framing controller: tracks start/stop markers on a valid/ready byte
// stream and drives message, stop-window and block-full levels.
module msg_frm_ctrl
    import msg_frm_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int LEN_W     = 5,
    parameter int BLK_LEN   = 16,
    parameter int STOP_HOLD = 4,
    parameter int TIMEOUT   = 32,
    parameter logic [DATA_W-1:0] SOM_CODE  = DATA_W'(SOM_CODE_DEF),
    parameter logic [DATA_W-1:0] STOP_CODE = DATA_W'(STOP_CODE_DEF)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              som_o,
    output logic              stop_o,
    output logic              blkf_o,
    output logic [LEN_W-1:0]  len_o,
    output logic              err_o
);

    localparam int HW = $clog2(STOP_HOLD + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    if (SOM_CODE == STOP_CODE) begin : g_bad_codes
        $fatal(1, "msg_frm_ctrl: SOM_CODE and STOP_CODE must differ");
    end

    frm_state_e state_q, state_d;

    logic [LEN_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [LEN_W-1:0] len_q, len_d;
    logic ready_q, ready_d;
    logic som_q, som_d;
    logic stop_q, stop_d;
    logic blkf_q, blkf_d;
    logic err_q, err_d;

    logic xfer, is_som, is_stop;
    logic restart, tmo;
    logic hold_load, hold_zero;
    logic tmo_load, tmo_zero;

    assign xfer    = valid_i & ready_q;
    assign is_som  = (data_i == SOM_CODE);
    assign is_stop = (data_i == STOP_CODE);
    assign cnt_inc = cnt_q + LEN_W'(1);

    // Idle timer is rearmed by every transfer and held armed outside a message.
    assign tmo_load  = xfer | (state_q == IDLE) | (state_q == STOP);
    assign hold_load = (state_d == STOP) & (state_q != STOP);

    msg_frm_tmr #(.W(TW)) u_tmo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (tmo_load),
        .val_i  (TW'(TIMEOUT - 1)),
        .en_i   (1'b1),
        .zero_o (tmo_zero)
    );

    msg_frm_tmr #(.W(HW)) u_hold (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (hold_load),
        .val_i  (HW'(STOP_HOLD - 1)),
        .en_i   (state_q == STOP),
        .zero_o (hold_zero)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        restart = 1'b0;
        tmo     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (xfer && is_som) begin
                    state_d = MSG;
                    cnt_d   = '0;
                end
            end
            MSG, BLK: begin
                if (xfer) begin
                    if (is_stop) begin
                        state_d = STOP;
                    end else if (is_som) begin
                        state_d = MSG;
                        cnt_d   = '0;
                        restart = 1'b1;
                    end else if (state_q == MSG) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == LEN_W'(BLK_LEN)) begin
                            state_d = BLK;
                        end
                    end
                end else if (tmo_zero) begin
                    state_d = STOP;
                    tmo     = 1'b1;
                end
            end
            STOP: begin
                if (hold_zero) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Block-full survives the stop window so the counter sees both flags.
    always_comb begin
        ready_d = (state_d != STOP);
        som_d   = (state_d == MSG) | (state_d == BLK);
        stop_d  = (state_d == STOP);
        blkf_d  = (state_d == BLK) | ((state_d == STOP) & blkf_q);
        err_d   = restart | tmo;
        len_d   = len_q;
        if (hold_load) begin
            len_d = LEN_W'(sat_len(32'(cnt_q), LEN_W));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ready_q <= 1'b0;
            som_q   <= 1'b0;
            stop_q  <= 1'b0;
            blkf_q  <= 1'b0;
            err_q   <= 1'b0;
            len_q   <= '0;
        end else begin
            ready_q <= ready_d;
            som_q   <= som_d;
            stop_q  <= stop_d;
            blkf_q  <= blkf_d;
            err_q   <= err_d;
            len_q   <= len_d;
        end
    end

    assign ready_o = ready_q;
    assign som_o   = som_q;
    assign stop_o  = stop_q;
    assign blkf_o  = blkf_q;
    assign err_o   = err_q;
    assign len_o   = len_q;

endmodule

// File: tb/tb_msg_frm_ctrl.sv
// Scoreboard bench for msg_frm_ctrl: message-level expectations are
// queued by the stimulus and checked when a stop window opens.
module tb_msg_frm_ctrl;

    localparam int DATA_W    = 8;
    localparam int LEN_W     = 5;
    localparam int BLK_LEN   = 16;
    localparam int STOP_HOLD = 4;
    localparam int TIMEOUT   = 32;
    localparam logic [7:0] SOM = 8'h7E;
    localparam logic [7:0] STP = 8'h7F;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] data_i;
    logic              valid_i;
    logic              ready_o;
    logic              som_o;
    logic              stop_o;
    logic              blkf_o;
    logic [LEN_W-1:0]  len_o;
    logic              err_o;

    typedef struct {
        int len;
        int blkf;
        int errs;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    msg_frm_ctrl #(
        .DATA_W    (DATA_W),
        .LEN_W     (LEN_W),
        .BLK_LEN   (BLK_LEN),
        .STOP_HOLD (STOP_HOLD),
        .TIMEOUT   (TIMEOUT),
        .SOM_CODE  (SOM),
        .STOP_CODE (STP)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .som_o   (som_o),
        .stop_o  (stop_o),
        .blkf_o  (blkf_o),
        .len_o   (len_o),
        .err_o   (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rnd_payload();
        logic [7:0] b;
        do b = 8'($urandom); while (b == SOM || b == STP);
        return b;
    endfunction

    // Present a byte; the transfer lands on the first rising edge with ready.
    task automatic send(input logic [7:0] b);
        int n;
        @(negedge clk);
        valid_i = 1'b1;
        data_i  = b;
        n = 0;
        while (!ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("ready_wait", 0, 1);
    endtask

    // Exactly g rising edges with valid_i low before the next send.
    task automatic idle(input int g);
        @(negedge clk);
        valid_i = 1'b0;
        repeat (g - 1) @(negedge clk);
    endtask

    task automatic push(input int k, input int errs);
        exp_t e;
        e.len  = (k > BLK_LEN) ? BLK_LEN : k;
        e.blkf = (k >= BLK_LEN) ? 1 : 0;
        e.errs = errs;
        sb_q.push_back(e);
    endtask

    task automatic rand_msg();
        int nseg, k;
        bit tmo_end;
        logic [7:0] j;
        nseg = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 3) : 1;
        tmo_end = ($urandom_range(0, 3) == 0);
        repeat ($urandom_range(0, 2)) begin
            j = $urandom_range(0, 1) ? STP : 8'($urandom);
            if (j == SOM) j = 8'h00;
            send(j);
        end
        k = 0;
        for (int s = 0; s < nseg; s++) begin
            send(SOM);
            k = $urandom_range(0, 24);
            for (int i = 0; i < k; i++) begin
                if ($urandom_range(0, 7) == 0)
                    idle($urandom_range(1, TIMEOUT - 1));
                send(rnd_payload());
            end
        end
        push(k, nseg - 1 + (tmo_end ? 1 : 0));
        if (tmo_end) idle(TIMEOUT);
        else send(STP);
    endtask

    // Monitor: one scoreboard entry per opened stop window.
    initial begin
        int err_cnt, win, win_blkf;
        bit prev_stop;
        exp_t e;
        err_cnt = 0;
        win = 0;
        win_blkf = 0;
        prev_stop = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                err_cnt = 0;
                win = 0;
                prev_stop = 1'b0;
            end else begin
                if (err_o) err_cnt++;
                if (stop_o && !prev_stop) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_stop", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("len", int'(len_o), e.len);
                        chk("blkf_close", int'(blkf_o), e.blkf);
                        chk("err_pulses", err_cnt, e.errs);
                    end
                    chk("ready_in_stop", int'(ready_o), 0);
                    chk("som_in_stop", int'(som_o), 0);
                    err_cnt = 0;
                    win = 1;
                    win_blkf = int'(blkf_o);
                end else if (stop_o) begin
                    win++;
                    chk("blkf_hold", int'(blkf_o), win_blkf);
                end else if (prev_stop) begin
                    chk("stop_len", win, STOP_HOLD);
                    chk("blkf_idle", int'(blkf_o), 0);
                    chk("ready_after", int'(ready_o), 1);
                end
                prev_stop = stop_o;
            end
        end
    end

    initial begin
        int n;
        rst_n   = 1'b0;
        valid_i = 1'b0;
        data_i  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", int'(ready_o), 0);
        chk("rst_som", int'(som_o), 0);
        chk("rst_len", int'(len_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", int'(ready_o), 1);
        chk("rel_som", int'(som_o), 0);
        chk("rel_stop", int'(stop_o), 0);
        chk("rel_blkf", int'(blkf_o), 0);
        chk("rel_err", int'(err_o), 0);
        chk("rel_len", int'(len_o), 0);

        send(SOM);
        idle(1);
        chk("som_open", int'(som_o), 1);
        repeat (5) send(rnd_payload());
        push(5, 0);
        send(STP);

        send(SOM);
        repeat (15) send(rnd_payload());
        idle(1);
        chk("blkf_pre", int'(blkf_o), 0);
        send(rnd_payload());
        idle(1);
        chk("blkf_at16", int'(blkf_o), 1);
        repeat (4) send(rnd_payload());
        idle(1);
        chk("blkf_som", int'(som_o), 1);
        push(20, 0);
        send(STP);

        send(SOM);
        repeat (3) send(rnd_payload());
        send(SOM);
        repeat (2) send(rnd_payload());
        push(2, 1);
        send(STP);

        send(SOM);
        send(rnd_payload());
        push(1, 1);
        idle(TIMEOUT);

        send(SOM);
        send(rnd_payload());
        idle(TIMEOUT - 1);
        send(rnd_payload());
        push(2, 0);
        send(STP);

        send(SOM);
        repeat (18) send(rnd_payload());
        idle(1);
        chk("pre_rst_blkf", int'(blkf_o), 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_som", int'(som_o), 0);
        chk("arst_blkf", int'(blkf_o), 0);
        chk("arst_len", int'(len_o), 0);
        chk("arst_ready", int'(ready_o), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arel_ready", int'(ready_o), 1);
        chk("arel_len", int'(len_o), 0);

        repeat (40) rand_msg();

        idle(1);
        n = 0;
        while (!ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (STOP_HOLD + 2) @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/msg_frm_ctrl.md
Name: msg_frm_ctrl

Overview:
Upstream framing controller for the stop-count register-counter stage. Parses a valid/ready byte stream for start and stop marker codes. Produces the level/flag signals the counter consumes: som_o (message in progress), stop_o (stop window) and blkf_o (block-full, length overflow). Also reports the latched message length and error pulses.

Parameters:
DATA_W, 8, stream byte width
LEN_W, 5, width of payload length counter / len_o
BLK_LEN, 16, payload bytes allowed before block-full (1..2^LEN_W-1)
STOP_HOLD, 4, cycles stop_o is held after a stop marker (>=1)
TIMEOUT, 32, idle cycles inside a message before forced stop (>=2)
SOM_CODE, 8'h7E, start-of-message marker
STOP_CODE, 8'h7F, stop marker

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
data_i  in  DATA_W  stream byte
valid_i  in  1  data_i valid
ready_o  out  1  block accepts data_i; transfer = valid_i & ready_o
som_o  out  1  high while a message is open
stop_o  out  1  high during stop window
blkf_o  out  1  block-full: payload reached BLK_LEN, further payload dropped
len_o  out  LEN_W  payload length of last closed message, saturating
err_o  out  1  one-cycle pulse: restart-in-message or timeout

Behaviour:
- Reset (rst_ni=0, async): state=IDLE. som_o, stop_o, blkf_o, err_o, len_o = 0. ready_o=0 while in reset. First cycle after release: ready_o=1.
- All outputs are registered. Each reaction appears on the cycle after the accepting edge.
- States: IDLE, MSG, BLK, STOP.
- IDLE: ready_o=1. A transfer with SOM_CODE -> MSG, som_o=1, byte_cnt=0. Any other byte is accepted and discarded.
- MSG: ready_o=1.
  - Payload transfer (neither code): byte_cnt+1, idle timer cleared.
  - If byte_cnt reaches BLK_LEN -> BLK, blkf_o=1.
  - STOP_CODE transfer -> STOP.
  - SOM_CODE transfer -> restart: byte_cnt=0, stay MSG, err_o pulse.
- BLK: ready_o=1, som_o=1, blkf_o=1. Payload bytes are accepted and dropped; byte_cnt is frozen at BLK_LEN.
  - STOP_CODE -> STOP.
  - SOM_CODE -> MSG with byte_cnt=0, blkf_o=0, err_o pulse.
- Timeout: in MSG or BLK, TIMEOUT consecutive cycles without a transfer -> STOP plus err_o pulse. A transfer on the TIMEOUT-th cycle wins; the timer is cleared.
- STOP entry:
  - len_o <= byte_cnt (saturate at 2^LEN_W-1).
  - som_o=0, stop_o=1 for exactly STOP_HOLD cycles, ready_o=0.
  - blkf_o keeps its value through STOP and clears on return to IDLE. The counter stage therefore sees stop_i and blkf_i overlap.
- STOP exit: after STOP_HOLD cycles -> IDLE, stop_o=0, blkf_o=0, ready_o=1.
- Simultaneity:
  - Transfer priority: STOP_CODE and SOM_CODE are checked before the payload path.
  - valid_i while ready_o=0 is not a transfer; the source must hold data_i stable.
  - err_o never asserts in IDLE or STOP.
- Reset mid-message: immediate return to IDLE values. len_o is cleared, not preserved.
- If SOM_CODE==STOP_CODE the configuration is illegal: elaboration-time assertion.

Decomposition:
- Package msg_frm_pkg holds:
  - state enum frm_state_e {IDLE, MSG, BLK, STOP}
  - default SOM/STOP code localparams
  - a function sat_len(cnt, LEN_W)
- One sub-module msg_frm_tmr: loadable down-counter with zero flag.
  - Instanced twice: STOP_HOLD window and TIMEOUT idle timer.
  - Ports clk_i, rst_ni, load_i, val_i, en_i, zero_o.

Test Plan:
- Reset release, valid_i=0 -> all outputs 0, ready_o=1 from first cycle after rst_ni=1.
- SOM, 5 payload bytes, STOP -> som_o high 6 cycles (through STOP accept), stop_o high 4 cycles, len_o=5, blkf_o never 1, err_o never 1.
- SOM, 20 payload bytes, STOP -> blkf_o=1 the cycle after the 16th payload byte; bytes 17-20 dropped. During STOP, stop_o and blkf_o are both 1 for 4 cycles. len_o=16; blkf_o=0 on IDLE.
- SOM, 3 bytes, SOM, 2 bytes, STOP -> one err_o pulse after the second SOM, len_o=2.
- SOM, 1 byte, then valid_i=0 for 32 cycles -> err_o pulse, stop_o 4 cycles, len_o=1. Repeat with a byte on cycle 32 -> no timeout.
- rst_ni low for 1 cycle asynchronously mid-BLK -> outputs 0 immediately (before next clk edge), len_o=0, ready_o=1 after release. STOP_CODE sent during stop window with valid_i=1 -> not accepted.
